// File: rtl/reg_dump_unit_if.sv
// Bundles the dump request, register-file read port and output stream of reg_dump_unit.
// The master modport is the dump unit; the slave modport is its environment.
interface reg_dump_unit_if #(
  parameter int DATA_W = 16,
  parameter int AW     = 3
);
  logic              start;
  logic [AW-1:0]     first_reg;
  logic [AW-1:0]     last_reg;
  logic [AW-1:0]     rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [AW-1:0]     out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;

  modport master (
    input  start, first_reg, last_reg, rf_rdata, out_ready,
    output rf_raddr, out_valid, out_addr, out_data, out_last, busy, done
  );

  modport slave (
    output start, first_reg, last_reg, rf_rdata, out_ready,
    input  rf_raddr, out_valid, out_addr, out_data, out_last, busy, done
  );
endinterface

// File: rtl/reg_dump_unit.sv
// Streams an inclusive, wrapping range of register-file entries as (addr, data, last)
// words over a valid/ready handshake, one READ bubble per word.
module reg_dump_unit #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8
) (
  input  logic             clk,
  input  logic             reset,
  reg_dump_unit_if.master  bus
);
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] SEND = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]        state;
  logic [AW-1:0]     idx;
  logic [AW-1:0]     last_idx;
  logic [AW-1:0]     idx_next;
  logic              out_valid_q;
  logic [AW-1:0]     out_addr_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_last_q;

  // Index advance wraps explicitly so non-power-of-two register counts stay in range.
  always_comb begin
    idx_next = idx + AW'(1);
    if (idx == AW'(NUM_REGS - 1)) idx_next = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      last_idx    <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            idx      <= bus.first_reg;
            last_idx <= bus.last_reg;
            state    <= READ;
          end
        end
        READ: begin
          out_data_q  <= bus.rf_rdata;
          out_addr_q  <= idx;
          out_last_q  <= (idx == last_idx);
          out_valid_q <= 1'b1;
          state       <= SEND;
        end
        SEND: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (idx == last_idx) begin
              out_last_q <= 1'b0;
              state      <= DONE;
            end else begin
              idx   <= idx_next;
              state <= READ;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.rf_raddr  = idx;
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = (state == READ) || (state == SEND);
  assign bus.done      = (state == DONE);
endmodule

// File: tb/tb_reg_dump_unit.sv
// Directed bench for reg_dump_unit: hand-computed word sequences, latency, stall, restart and reset checks.
module tb_reg_dump_unit;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  logic [15:0] rf [8];
  logic [2:0]  ea [8];
  logic [15:0] ed [8];

  reg_dump_unit_if #(.DATA_W(16), .AW(3)) bus ();

  reg_dump_unit #(.DATA_W(16), .NUM_REGS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.rf_rdata = rf[bus.rf_raddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives out_ready and checks each accepted word against ea/ed; returns first-valid cycle
  // and the cycle of the final handshake edge, both counted from the start edge.
  task automatic collect(input int nexp, input int stall_at, input int stall_len,
                         input bit disturb, output int first_c, output int cyc);
    int c, got, stall;
    logic [15:0] hd;
    logic [2:0]  ha;
    c = 0; got = 0; stall = 0; first_c = -1; cyc = -1; hd = '0; ha = '0;
    while (got < nexp && c < 100) begin
      if (disturb && c == 2) begin
        bus.start = 1'b1; bus.first_reg = 3'd5; bus.last_reg = 3'd5;
      end else if (disturb && c == 3) begin
        bus.start = 1'b0;
      end
      if (bus.out_valid) begin
        if (first_c < 0) first_c = c;
        if (got == stall_at && stall < stall_len) begin
          bus.out_ready = 1'b0;
          if (stall > 0) begin
            chk("hold_data", 32'(bus.out_data), 32'(hd));
            chk("hold_addr", 32'(bus.out_addr), 32'(ha));
          end
          hd = bus.out_data; ha = bus.out_addr;
          stall++;
        end else begin
          bus.out_ready = 1'b1;
          chk("word_addr", 32'(bus.out_addr), 32'(ea[got]));
          chk("word_data", 32'(bus.out_data), 32'(ed[got]));
          chk("word_last", 32'(bus.out_last), 32'(got == nexp - 1));
          got++;
          if (got == nexp) cyc = c + 1;
        end
      end else begin
        bus.out_ready = 1'b1;
        chk("raddr", 32'(bus.rf_raddr), 32'(ea[got]));
      end
      tick();
      c++;
    end
    chk("word_count", 32'(got), 32'(nexp));
  endtask

  task automatic check_done();
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("done_busy", 32'(bus.busy), 32'd0);
    chk("done_valid", 32'(bus.out_valid), 32'd0);
    chk("done_last", 32'(bus.out_last), 32'd0);
    tick();
    chk("done_cleared", 32'(bus.done), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  task automatic launch(input logic [2:0] f, input logic [2:0] l);
    bus.first_reg = f; bus.last_reg = l; bus.start = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_busy", 32'(bus.busy), 32'd1);
    chk("start_raddr", 32'(bus.rf_raddr), 32'(f));
    chk("start_valid", 32'(bus.out_valid), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_addr"},  32'(bus.out_addr),  32'd0);
    chk({tag, "_data"},  32'(bus.out_data),  32'd0);
    chk({tag, "_last"},  32'(bus.out_last),  32'd0);
    chk({tag, "_raddr"}, 32'(bus.rf_raddr),  32'd0);
    chk({tag, "_busy"},  32'(bus.busy),      32'd0);
    chk({tag, "_done"},  32'(bus.done),      32'd0);
  endtask

  initial begin
    int fc, cy;
    n_checks = 0; n_fail = 0;
    reset = 1'b0;
    bus.start = 1'b0; bus.first_reg = '0; bus.last_reg = '0; bus.out_ready = 1'b0;
    rf[0] = 16'd0;  rf[1] = 16'd30; rf[2] = 16'd20; rf[3] = 16'd50;
    rf[4] = 16'd10; rf[5] = 16'd0;  rf[6] = 16'd6;  rf[7] = 16'd7;
    #2;
    check_zero("reset");
    tick(); tick();
    reset = 1'b1;

    // Range 1..4 with out_ready held high
    ea[0] = 3'd1; ea[1] = 3'd2; ea[2] = 3'd3; ea[3] = 3'd4;
    ed[0] = 16'd30; ed[1] = 16'd20; ed[2] = 16'd50; ed[3] = 16'd10;
    launch(3'd1, 3'd4);
    collect(4, -1, 0, 1'b0, fc, cy);
    chk("basic_first_valid", 32'(fc), 32'd1);
    chk("basic_cycles", 32'(cy), 32'd8);
    check_done();
    chk("idle_raddr_stable", 32'(bus.rf_raddr), 32'd4);

    // Wrapping range 6..1
    ea[0] = 3'd6; ea[1] = 3'd7; ea[2] = 3'd0; ea[3] = 3'd1;
    ed[0] = 16'd6; ed[1] = 16'd7; ed[2] = 16'd0; ed[3] = 16'd30;
    launch(3'd6, 3'd1);
    collect(4, -1, 0, 1'b0, fc, cy);
    chk("wrap_cycles", 32'(cy), 32'd8);
    check_done();

    // Single-register range 3..3
    ea[0] = 3'd3; ed[0] = 16'd50;
    launch(3'd3, 3'd3);
    collect(1, -1, 0, 1'b0, fc, cy);
    chk("single_first_valid", 32'(fc), 32'd1);
    chk("single_cycles", 32'(cy), 32'd2);
    check_done();

    // Five-cycle stall on word 2
    ea[0] = 3'd1; ea[1] = 3'd2; ea[2] = 3'd3; ea[3] = 3'd4;
    ed[0] = 16'd30; ed[1] = 16'd20; ed[2] = 16'd50; ed[3] = 16'd10;
    launch(3'd1, 3'd4);
    collect(4, 1, 5, 1'b0, fc, cy);
    chk("stall_cycles", 32'(cy), 32'd13);
    check_done();

    // Start pulse and range change mid-dump are ignored
    launch(3'd1, 3'd4);
    collect(4, -1, 0, 1'b1, fc, cy);
    chk("disturb_cycles", 32'(cy), 32'd8);
    bus.start = 1'b0;
    check_done();

    // Reset during SEND of word 2, then a fresh full dump
    launch(3'd1, 3'd4);
    tick();
    chk("pre_rst_valid1", 32'(bus.out_valid), 32'd1);
    tick();
    tick();
    chk("pre_rst_valid2", 32'(bus.out_valid), 32'd1);
    chk("pre_rst_addr2", 32'(bus.out_addr), 32'd2);
    reset = 1'b0;
    #1;
    check_zero("midrst");
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_idle", 32'(bus.busy), 32'd0);
    launch(3'd1, 3'd4);
    collect(4, -1, 0, 1'b0, fc, cy);
    chk("restart_cycles", 32'(cy), 32'd8);
    check_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_dump_unit.md
REG_DUMP_UNIT -- requirements
Module: reg_dump_unit

Interface
REQ-001 Parameter DATA_W, default 16, register data width.
REQ-002 Parameter NUM_REGS, default 8, register count; index width AW = 3.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous active-low reset (0 = in reset).
REQ-006 start  input  1  dump request, sampled only in IDLE.
REQ-007 first_reg  input  AW  first register index, latched on accepted start.
REQ-008 last_reg  input  AW  last register index (inclusive), latched on accepted start.
REQ-009 rf_raddr  output  AW  register-file read address; rf read is combinational.
REQ-010 rf_rdata  input  DATA_W  register-file read data for rf_raddr, same cycle.
REQ-011 out_valid  output  1  out_addr/out_data/out_last valid.
REQ-012 out_ready  input  1  consumer accepts the word when high with out_valid.
REQ-013 out_addr  output  AW  index of the register in out_data.
REQ-014 out_data  output  DATA_W  captured register value.
REQ-015 out_last  output  1  high with the final word of the dump.
REQ-016 busy  output  1  high in READ and SEND states.
REQ-017 done  output  1  single-cycle pulse after the final word is accepted.

Function
REQ-018 FSM states SHALL be IDLE, READ, SEND, DONE.
REQ-019 IDLE: start=1 at a clock edge -> latch first_reg into index idx and last_reg into end; go READ.
REQ-020 READ: rf_raddr = idx; at next edge capture out_data<=rf_rdata, out_addr<=idx, out_last<=(idx==end), out_valid<=1; go SEND.
REQ-021 SEND: out_valid, out_addr, out_data, out_last SHALL stay stable until the edge where out_ready=1.
REQ-022 SEND handshake with idx!=end -> out_valid<=0, idx<=idx+1 modulo NUM_REGS, go READ (one bubble cycle per word).
REQ-023 SEND handshake with idx==end -> out_valid<=0, out_last<=0, go DONE.
REQ-024 DONE: done=1 for exactly this cycle; go IDLE next edge.
REQ-025 Latency: first out_valid SHALL assert 2 cycles after the start edge; word n+1 appears 2 cycles after handshake of word n.
REQ-026 Word count = ((end - first) mod NUM_REGS) + 1; first==end dumps exactly one register; first>end wraps through index NUM_REGS-1 to 0.
REQ-027 start while busy or in DONE SHALL be ignored; first_reg/last_reg changes after latch SHALL have no effect.
REQ-028 rf_raddr SHALL equal idx in every state (don't-care value outside READ, but stable).
REQ-029 out_ready while out_valid=0 SHALL have no effect.
REQ-030 No word SHALL be dropped or duplicated regardless of out_ready stall length.

Reset
REQ-031 reset=0 SHALL immediately (asynchronously) force state IDLE, idx=0, end=0, rf_raddr=0, out_valid=0, out_addr=0, out_data=0, out_last=0, busy=0, done=0.
REQ-032 Reset mid-dump SHALL abandon the dump; after release the block waits for a new start.
REQ-033 Reset release SHALL be followed by at least one edge before start is honoured normally (start on the first edge after release is accepted).

Verification
REQ-034 Preload R1=30, R2=20, R3=50, R4=10, out_ready=1, start with first=1,last=4 -> words (1,30),(2,20),(3,50),(4,10,last), done pulse, 8 cycles from start to final handshake.
REQ-035 first=6,last=1, R6=6,R7=7,R0=0,R1=30 -> words in order 6,7,0,1; out_last only on index 1.
REQ-036 first=last=3, R3=50 -> single word (3,50) with out_last=1, then done.
REQ-037 Hold out_ready=0 for 5 cycles on word 2 -> out_valid/out_data held stable, no skip, dump completes correctly after release.
REQ-038 Pulse start and change first_reg/last_reg during dump -> ignored, original range completes.
REQ-039 Assert reset during SEND of word 2 -> all outputs zero immediately; new start after release dumps full requested range from first_reg.
